// File: rtl/shift_seq_ctrl_if.sv
// Parallel word handshake into the shift sequencer: valid/data from upstream, ready back.
interface shift_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Serialises one word LSB-first into an MSB-in right shift register (WIDTH shift cycles),
// then idles GAP cycles; done pulses the cycle after the last shift; in_ready only in IDLE.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic                clk,
   input  logic                rst,
   shift_seq_ctrl_if.slave     up,
   input  logic                abort,
   output logic                sr_a,
   output logic                sr_shift_en,
   output logic                busy,
   output logic                done
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic [CW-1:0]     bitcnt_q, bitcnt_d;
   logic [3:0]        gapcnt_q, gapcnt_d;
   logic              done_q, done_d;
   logic              sr_a_q, sr_a_d;
   logic              sr_shift_en_q, sr_shift_en_d;
   logic              busy_q, busy_d;

   assign up.in_ready = (state_q == S_IDLE) && !abort;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (up.in_valid && !abort) begin
               hold_d   = up.in_data;
               bitcnt_d = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d  = S_IDLE;
               hold_d   = '0;
               bitcnt_d = '0;
               gapcnt_d = '0;
            end else begin
               hold_d   = hold_q >> 1;
               bitcnt_d = bitcnt_q + CW'(1);
               if (bitcnt_q == LAST_BIT) begin
                  done_d = 1'b1;
                  if (GAP > 0) begin
                     state_d  = S_GAP;
                     gapcnt_d = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d  = S_IDLE;
               hold_d   = '0;
               bitcnt_d = '0;
               gapcnt_d = '0;
            end else begin
               gapcnt_d = gapcnt_q + 4'd1;
               if (gapcnt_q == GAP_LAST) state_d = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            hold_d   = '0;
            bitcnt_d = '0;
            gapcnt_d = '0;
         end
      endcase

      // Outputs are registered copies of what the next state decodes to.
      sr_shift_en_d = (state_d == S_SHIFT);
      sr_a_d        = (state_d == S_SHIFT) && hold_d[0];
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         hold_q        <= '0;
         bitcnt_q      <= '0;
         gapcnt_q      <= '0;
         done_q        <= 1'b0;
         sr_a_q        <= 1'b0;
         sr_shift_en_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         bitcnt_q      <= bitcnt_d;
         gapcnt_q      <= gapcnt_d;
         done_q        <= done_d;
         sr_a_q        <= sr_a_d;
         sr_shift_en_q <= sr_shift_en_d;
         busy_q        <= busy_d;
      end
   end

   assign sr_a        = sr_a_q;
   assign sr_shift_en = sr_shift_en_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: one instance with GAP=1, one with GAP=0 for back-to-back words.
module tb_shift_seq_ctrl;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic abort1, abort0;
   logic sr_a1, sh1, busy1, done1;
   logic sr_a0, sh0, busy0, done0;

   shift_seq_ctrl_if #(.WIDTH(W)) if1 ();
   shift_seq_ctrl_if #(.WIDTH(W)) if0 ();

   shift_seq_ctrl #(.WIDTH(W), .GAP(1)) dut1 (
      .clk(clk), .rst(rst), .up(if1), .abort(abort1),
      .sr_a(sr_a1), .sr_shift_en(sh1), .busy(busy1), .done(done1)
   );
   shift_seq_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .up(if0), .abort(abort0),
      .sr_a(sr_a0), .sr_shift_en(sh0), .busy(busy0), .done(done0)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Observation record: {shift_en, sr_a, done, in_ready, busy}
   typedef logic [4:0] obs_t;
   obs_t q1[$];
   obs_t q0[$];

   // Downstream MSB-in right shift registers
   logic [W-1:0] sreg1 = '0;
   logic [W-1:0] sreg0 = '0;
   always @(posedge clk) if (sh1 === 1'b1) sreg1 <= {sr_a1, sreg1[W-1:1]};
   always @(posedge clk) if (sh0 === 1'b1) sreg0 <= {sr_a0, sreg0[W-1:1]};

   function automatic obs_t ob(input logic s, input logic a, input logic d,
                               input logic r, input logic b);
      return {s, a, d, r, b};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input bit sel, input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         if (sel) q1.push_back(ob(1'b1, d[i], 1'b0, 1'b0, 1'b1));
         else     q0.push_back(ob(1'b1, d[i], 1'b0, 1'b0, 1'b1));
      end
   endtask

   always @(negedge clk) begin
      if (sh1 === 1'b1 || done1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut1_unexpected_output: got %b required none",
                     {sh1, sr_a1, done1, if1.in_ready, busy1});
         end else begin
            chk("dut1_out", 8'({sh1, sr_a1, done1, if1.in_ready, busy1}), 8'(q1.pop_front()));
         end
      end
      if (sh0 === 1'b1 || done0 === 1'b1) begin
         if (q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dut0_unexpected_output: got %b required none",
                     {sh0, sr_a0, done0, if0.in_ready, busy0});
         end else begin
            chk("dut0_out", 8'({sh0, sr_a0, done0, if0.in_ready, busy0}), 8'(q0.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; abort1 = 1'b0; abort0 = 1'b0;
      if1.in_valid = 1'b1; if1.in_data = 4'hF;
      if0.in_valid = 1'b1; if0.in_data = 4'hF;
      tick(); tick();
      chk("rst_in_ready",  8'(if1.in_ready), 8'd1);
      chk("rst_shift_en",  8'(sh1),          8'd0);
      chk("rst_busy",      8'(busy1),        8'd0);
      chk("rst_done",      8'(done1),        8'd0);
      chk("rst_sr_a",      8'(sr_a1),        8'd0);
      chk("rst_busy_g0",   8'(busy0),        8'd0);
      if1.in_valid = 1'b0; if0.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("no_start_in_reset", 8'(busy1), 8'd0);

      // Single word, GAP=1
      if1.in_valid = 1'b1; if1.in_data = 4'b0011;
      push_word(1'b1, 4'b0011);
      q1.push_back(ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0;
      repeat (4) tick();
      chk("gap_in_ready",     8'(if1.in_ready), 8'd0);
      tick();
      chk("ready_after_gap",  8'(if1.in_ready), 8'd1);
      chk("idle_busy",        8'(busy1),        8'd0);
      chk("sreg_single",      8'(sreg1),        8'b0011);

      // Upstream stall with wandering data
      for (int i = 0; i < 3; i++) begin
         if1.in_data = 4'(4'hF - 4'(3 * i));
         tick();
         chk("stall_shift_en", 8'(sh1), 8'd0);
      end
      if1.in_valid = 1'b1; if1.in_data = 4'b0110;
      push_word(1'b1, 4'b0110);
      q1.push_back(ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0; if1.in_data = 4'hF;
      repeat (5) tick();
      chk("sreg_after_stall", 8'(sreg1), 8'b0110);

      // Abort in IDLE blocks the handshake
      if1.in_valid = 1'b1; abort1 = 1'b1;
      #1;
      chk("abort_idle_ready", 8'(if1.in_ready), 8'd0);
      tick();
      chk("abort_idle_no_start", 8'(busy1), 8'd0);
      abort1 = 1'b0; if1.in_valid = 1'b0;
      tick();

      // Abort during the 2nd shift cycle
      if1.in_valid = 1'b1; if1.in_data = 4'b1011;
      q1.push_back(ob(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      q1.push_back(ob(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0;
      tick();
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      #1;
      chk("abort_shift_en", 8'(sh1),          8'd0);
      chk("abort_busy",     8'(busy1),        8'd0);
      chk("abort_done",     8'(done1),        8'd0);
      chk("abort_ready",    8'(if1.in_ready), 8'd1);
      repeat (3) tick();
      if1.in_valid = 1'b1; if1.in_data = 4'b1000;
      push_word(1'b1, 4'b1000);
      q1.push_back(ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0;
      repeat (5) tick();
      chk("sreg_after_abort", 8'(sreg1), 8'b1000);

      // Abort on the final shift edge: no done
      if1.in_valid = 1'b1; if1.in_data = 4'b1111;
      push_word(1'b1, 4'b1111);
      tick();
      if1.in_valid = 1'b0;
      repeat (3) tick();
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      chk("last_abort_done", 8'(done1), 8'd0);
      chk("last_abort_busy", 8'(busy1), 8'd0);
      repeat (2) tick();

      // Reset mid-transfer, then hold must start clean
      if1.in_valid = 1'b1; if1.in_data = 4'b1111;
      q1.push_back(ob(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      q1.push_back(ob(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rstmid_shift_en", 8'(sh1),          8'd0);
      chk("rstmid_busy",     8'(busy1),        8'd0);
      chk("rstmid_done",     8'(done1),        8'd0);
      chk("rstmid_ready",    8'(if1.in_ready), 8'd1);
      repeat (2) tick();
      if1.in_valid = 1'b1; if1.in_data = 4'b0100;
      push_word(1'b1, 4'b0100);
      q1.push_back(ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      if1.in_valid = 1'b0;
      repeat (5) tick();
      chk("sreg_after_rst", 8'(sreg1), 8'b0100);

      // Back-to-back, GAP=0: done coincides with in_ready in the IDLE cycle
      if0.in_valid = 1'b1; if0.in_data = 4'hA;
      push_word(1'b0, 4'hA);
      q0.push_back(ob(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      push_word(1'b0, 4'h5);
      q0.push_back(ob(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      tick();
      if0.in_data = 4'h5;
      repeat (4) tick();
      chk("b2b_idle_shift_en", 8'(sh0), 8'd0);
      tick();
      if0.in_valid = 1'b0;
      repeat (5) tick();
      chk("sreg_b2b", 8'(sreg0), 8'h5);

      chk("q1_drained", 8'(q1.size()), 8'd0);
      chk("q0_drained", 8'(q0.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
